// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Converts a loaded binary value to BCD with a sequential double-dabble FSM.
//   When a conversion finishes, all display codes are replaced in one cycle.
//   A free-running scanner multiplexes those codes onto one shared BCD decoder.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load        start a conversion of value (ignored while busy)
//   value       binary value to show
//   en          1: digit enables scan; 0: all enables high (display off)
//   busy        conversion in progress
//   done        one-cycle pulse when the new digits become visible
//   ovf         last accepted value exceeded 10^NUM_DIGITS-1
//   digit_code  BCD code to the decoder, 4'hF = blank
//   an          active-low digit enables
module display_scan_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter int BIN_W         = 14,
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [BIN_W-1:0]      value,
  input  logic                  en,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [3:0]            digit_code,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] codes_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_UPDATE  = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
    end
    return r;
  endfunction

  // Turns the BCD result into display codes: overflow blanks everything,
  // leading zeros above the top nonzero digit blank optionally, digit 0 never.
  function automatic codes_t format_codes(input logic [BCD_W-1:0] b, input logic over);
    codes_t c;
    logic   seen;
    seen = 1'b0;
    c    = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (over) begin
        c[i] = 4'hF;
      end else if (i == 0) begin
        c[i] = b[3:0];
      end else begin
        seen = seen | (b[4*i +: 4] != 4'd0);
        c[i] = (BLANK_LEADING && !seen) ? 4'hF : b[4*i +: 4];
      end
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  codes_t           codes_q, codes_d;

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            digit_code_q, digit_code_d;

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    codes_d    = codes_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          bin_d      = value;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = ({{(64-BIN_W){1'b0}}, value} > MAX_VAL);
          busy_d     = 1'b1;
          state_d    = S_CONVERT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONVERT: begin
        {bcd_d, bin_d} = {dabble_adjust(bcd_q), bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_UPDATE;
        end else begin
          state_d = S_CONVERT;
        end
      end
      S_UPDATE: begin
        // All codes change on the same edge so the scanner never shows a mix.
        codes_d = format_codes(bcd_q, ovf_pend_q);
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Free-running scanner; outputs lag the index by one register stage.
  always_comb begin
    if (presc_q == PRE_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : (idx_q + IDX_W'(1));
    end else begin
      presc_d = presc_q + PRE_W'(1);
      idx_d   = idx_q;
    end
    an_d         = en ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    digit_code_d = codes_q[idx_q];
  end

  // State registers for FSM, codes and scanner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      ovf_pend_q   <= 1'b0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      codes_q      <= '1;
      presc_q      <= '0;
      idx_q        <= '0;
      an_q         <= '1;
      digit_code_q <= 4'hF;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      ovf_pend_q   <= ovf_pend_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      codes_q      <= codes_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      digit_code_q <= digit_code_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf        = ovf_q;
  assign digit_code = digit_code_q;
  assign an         = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl: two instances (leading-zero blanking on
// and off) share stimulus and are checked every cycle against a transaction
// level model, plus directed literal checks of the scanned digits.
module tb_display_scan_ctrl;

  localparam int R = 4;
  localparam int N = 4;
  localparam int W = 14;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic [W-1:0]  value;
  logic          en;
  logic          busy0, done0, ovf0, busy1, done1, ovf1;
  logic [3:0]    dc0, dc1;
  logic [N-1:0]  an0, an1;

  int n_cmp = 0;
  int n_bad = 0;

  display_scan_ctrl #(.NUM_DIGITS(N), .BIN_W(W), .REFRESH_DIV(R), .BLANK_LEADING(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .en(en),
    .busy(busy0), .done(done0), .ovf(ovf0), .digit_code(dc0), .an(an0)
  );

  display_scan_ctrl #(.NUM_DIGITS(N), .BIN_W(W), .REFRESH_DIV(R), .BLANK_LEADING(1'b0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .en(en),
    .busy(busy1), .done(done1), .ovf(ovf1), .digit_code(dc1), .an(an1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected code for one display position, from decimal arithmetic.
  function automatic logic [3:0] exp_digit(input int v, input int pos, input bit bl);
    int p;
    p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    if (v > 9999) return 4'hF;
    if (bl && pos > 0 && v < p) return 4'hF;
    return 4'((v / p) % 10);
  endfunction

  // Behavioural model: scan position = (edges since reset / R) mod N;
  // an accepted load makes the new digits visible BIN_W+1 edges later.
  int         k;
  int         busy_left;
  int         pend_v;
  logic [3:0] m_codes [2][N];
  logic [3:0] m_an [2];
  logic [3:0] m_dc [2];
  logic       m_busy, m_done, m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k         <= 0;
      busy_left <= 0;
      pend_v    <= 0;
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_ovf     <= 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_an[d] <= 4'hF;
        m_dc[d] <= 4'hF;
        for (int p = 0; p < N; p++) m_codes[d][p] <= 4'hF;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_an[d] <= en ? ~(4'b0001 << ((k / R) % N)) : 4'hF;
        m_dc[d] <= m_codes[d][(k / R) % N];
      end
      k      <= k + 1;
      m_done <= 1'b0;
      if (busy_left == 0) begin
        if (load) begin
          busy_left <= W + 1;
          pend_v    <= int'(value);
          m_busy    <= 1'b1;
        end
      end else begin
        busy_left <= busy_left - 1;
        if (busy_left == 1) begin
          for (int p = 0; p < N; p++) begin
            m_codes[0][p] <= exp_digit(pend_v, p, 1'b1);
            m_codes[1][p] <= exp_digit(pend_v, p, 1'b0);
          end
          m_ovf  <= (pend_v > 9999);
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("busy0", busy0, m_busy);
    chk("done0", done0, m_done);
    chk("ovf0", ovf0, m_ovf);
    chk("an0", an0, m_an[0]);
    chk("code0", dc0, m_dc[0]);
    chk("busy1", busy1, m_busy);
    chk("done1", done1, m_done);
    chk("ovf1", ovf1, m_ovf);
    chk("an1", an1, m_an[1]);
    chk("code1", dc1, m_dc[1]);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_value(input int v);
    load  = 1'b1;
    value = W'(v);
    step(1);
    load  = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done0 !== 1'b1 && t < 60) begin
      step(1);
      t++;
    end
    if (t >= 60) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Walk the scan and check the code shown at each position (digit3..digit0).
  task automatic check_scan(input int inst, input logic [15:0] exp_codes, input string nm);
    int         t;
    logic [3:0] want_an;
    logic [3:0] a;
    logic [3:0] c;
    step(1);
    for (int pos = 0; pos < N; pos++) begin
      want_an = ~(4'b0001 << pos);
      t = 0;
      a = (inst == 0) ? an0 : an1;
      while (a !== want_an && t < 40) begin
        step(1);
        t++;
        a = (inst == 0) ? an0 : an1;
      end
      c = (inst == 0) ? dc0 : dc1;
      if (t >= 40) chk({nm, "_scan_timeout"}, 32'd0, 32'd1);
      else chk(nm, c, exp_codes[4*pos +: 4]);
    end
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    load  = 1'b0;
    value = '0;
    en    = 1'b1;
    step(2);
    chk("rst_an", an0, 4'hF);
    chk("rst_code", dc0, 4'hF);
    chk("rst_busy", busy0, 1'b0);
    rst_n = 1'b1;
    step(3);

    // 1234: busy length, done pulse, scanned digits
    load_value(1234);
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 40) begin
      cnt++;
      step(1);
    end
    chk("busy_len", cnt, 32'd15);
    chk("done_after_busy", done0, 1'b1);
    check_scan(0, 16'h1234, "show_1234");

    // small values and leading-zero handling
    load_value(7);
    wait_done();
    check_scan(0, 16'hFFF7, "show_7_blank");
    check_scan(1, 16'h0007, "show_7_noblank");
    load_value(0);
    wait_done();
    check_scan(0, 16'hFFF0, "show_0_blank");
    check_scan(1, 16'h0000, "show_0_noblank");

    // overflow and recovery
    load_value(10000);
    wait_done();
    chk("ovf_set", ovf0, 1'b1);
    check_scan(0, 16'hFFFF, "show_ovf");
    check_scan(1, 16'hFFFF, "show_ovf_nb");
    load_value(9999);
    wait_done();
    chk("ovf_clr", ovf0, 1'b0);
    check_scan(0, 16'h9999, "show_9999");

    // loads while busy (mid-convert and during UPDATE) are dropped
    load  = 1'b1;
    value = W'(1234);
    step(1);
    load  = 1'b0;
    step(4);
    load  = 1'b1;
    value = W'(5555);
    step(1);
    load  = 1'b0;
    step(9);
    load  = 1'b1;
    step(1);
    load  = 1'b0;
    chk("done_drop", done0, 1'b1);
    step(1);
    chk("idle_after_drop", busy0, 1'b0);
    check_scan(0, 16'h1234, "show_dropped");

    // load in the done cycle is accepted
    load_value(1111);
    wait_done();
    load  = 1'b1;
    value = W'(42);
    step(1);
    load  = 1'b0;
    chk("busy_done_cycle_load", busy0, 1'b1);
    wait_done();
    check_scan(0, 16'hFF42, "show_42");

    // asynchronous reset mid-scan
    step(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", an0, 4'hF);
    chk("async_code", dc0, 4'hF);
    chk("async_busy", busy0, 1'b0);
    chk("async_done", done0, 1'b0);
    chk("async_ovf", ovf0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);

    // en=0 turns digits off next cycle
    en = 1'b0;
    step(1);
    chk("en_off_an0", an0, 4'hF);
    chk("en_off_an1", an1, 4'hF);
    step(9);
    en = 1'b1;
    step(1);
    chk("en_on_an", (an0 != 4'hF) ? 32'd1 : 32'd0, 32'd1);

    // reset during CONVERT cycle 7 of 9999
    load_value(9999);
    step(6);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy0, 1'b0);
    chk("abort_an", an0, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done0 === 1'b1) cnt++;
      step(1);
    end
    chk("abort_no_done", cnt, 32'd0);
    check_scan(0, 16'hFFFF, "abort_blank");

    // randomized traffic, checked by the model each cycle
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: value = W'($urandom_range(0, 9));
        1: value = W'($urandom_range(0, 9999));
        2: value = W'($urandom_range(9990, 10010));
        default: value = W'($urandom_range(0, 16383));
      endcase
      en = ($urandom_range(0, 15) != 0);
      step(1);
    end
    load = 1'b0;
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
